// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: data-memory initiator for byte/half/word load and store.
// Sub-word stores are done as read-modify-write of the full word.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_*              request handshake (valid/ready) and payload
//   resp_valid/rdata/err  one-cycle completion pulse with result
//   MemRead/MemWrite/addr/write_data/read_data  word-addressed memory port
//   load_count/store_count  saturating 16-bit completion counters, present
//                      only when MEM_ACCESS_CTRL_PERF_EN is defined
module mem_access_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int WIDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0] load_count,
  output logic [15:0] store_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_e;

  localparam logic [WIDX_W:0] LIM = (WIDX_W + 1)'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdat_q, wdat_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        oor;
  logic        misalign;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;
  logic [31:0] mask;
  logic [31:0] lane_dat;
  logic [31:0] merged;

  // Out of range if any index bit above WIDX_W is set or the low
  // index bits reach MEM_WORDS.
  assign oor = (|req_addr[31:WIDX_W+2]) ||
               ({1'b0, req_addr[WIDX_W+1:2]} >= LIM);

  assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign req_err = (req_size == 2'b11) || misalign || oor;

  always_comb begin
    lane_b = read_data[7:0];
    unique case (off_q)
      2'd0: lane_b = read_data[7:0];
      2'd1: lane_b = read_data[15:8];
      2'd2: lane_b = read_data[23:16];
      2'd3: lane_b = read_data[31:24];
    endcase
  end

  assign lane_h = off_q[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    ld_val = read_data;
    case (size_q)
      2'b00:   ld_val = {{24{sgn_q & lane_b[7]}}, lane_b};
      2'b01:   ld_val = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ld_val = read_data;
    endcase
  end

  // Store data is replicated across all lanes; the mask picks the lane.
  always_comb begin
    if (size_q == 2'b00) begin
      mask     = 32'h0000_00FF << {off_q, 3'b000};
      lane_dat = {4{wdat_q[7:0]}};
    end else begin
      mask     = off_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      lane_dat = {2{wdat_q}};
    end
  end

  assign merged = (read_data & ~mask) | (lane_dat & mask);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wdat_d  = wdat_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          off_d   = req_addr[1:0];
          wdat_d  = req_wdata[15:0];
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            addr_d = {2'b00, req_addr[31:2]};
            if (!req_write) begin
              state_d = RD;
            end else if (req_size == 2'b10) begin
              wd_d    = req_wdata;
              state_d = WR;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      RD: begin
        rdata_d = ld_val;
        state_d = RESP;
      end
      RMW_RD: begin
        wd_d    = merged;
        state_d = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
      wdat_q  <= 16'h0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;
  // Strobes gated by rst so a reset mid-operation never writes memory.
  assign MemRead    = !rst && (state_q == RD || state_q == RMW_RD);
  assign MemWrite   = !rst && (state_q == WR);
  assign addr       = addr_q;
  assign write_data = wd_q;

`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic [15:0] st_cnt_q, st_cnt_d;

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (state_q == RESP && !err_q) begin
      if (wr_q && st_cnt_q != 16'hFFFF) st_cnt_d = st_cnt_q + 16'd1;
      if (!wr_q && ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= 16'h0;
      st_cnt_q <= 16'h0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign load_count  = ld_cnt_q;
  assign store_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus random requests against a
// transaction-level model with a per-cycle output compare.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] load_count;
  logic [15:0] store_count;
`endif

  mem_access_ctrl #(.MEM_WORDS(64), .WIDX_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .addr(addr),
    .write_data(write_data),
    .read_data(read_data)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    .load_count(load_count),
    .store_count(store_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  assign read_data = (addr < 32'd64) ? mem[addr[5:0]] : 32'hDEAD_0000;

  always @(posedge clk)
    if (MemWrite && addr < 32'd64) mem[addr[5:0]] <= write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] b32(input bit x);
    return {31'b0, x};
  endfunction

  // Expected activity keyed by cycle number.
  logic [31:0] mr_a [int];
  logic [31:0] mw_a [int];
  logic [31:0] mw_d [int];
  logic [32:0] rsp  [int];
  int bs = -10;
  int be = -10;
  int m_loads = 0;
  int m_stores = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_rdata;
  logic [31:0] m_merged;
  bit m_err;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", b32(req_ready), b32(!(cyc >= bs && cyc <= be)));
      chk("MemRead", b32(MemRead), b32(mr_a.exists(cyc) != 0));
      if (mr_a.exists(cyc) != 0 && MemRead)
        chk("rd_addr", addr, mr_a[cyc]);
      chk("MemWrite", b32(MemWrite), b32(mw_a.exists(cyc) != 0));
      if (mw_a.exists(cyc) != 0 && MemWrite) begin
        chk("wr_addr", addr, mw_a[cyc]);
        chk("write_data", write_data, mw_d[cyc]);
      end
      chk("resp_valid", b32(resp_valid), b32(rsp.exists(cyc) != 0));
      if (rsp.exists(cyc) != 0 && resp_valid) begin
        chk("resp_err", b32(resp_err), b32(rsp[cyc][32]));
        chk("resp_rdata", resp_rdata, rsp[cyc][31:0]);
      end
    end
  end

  // Transaction-level model: rules applied to byte arithmetic on ref_mem.
  task automatic model_req(input int A, input bit w, input logic [1:0] sz,
                           input bit sg, input logic [31:0] a,
                           input logic [31:0] wd);
    int idx;
    int off;
    int nb;
    logic [63:0] v;
    logic [63:0] msk;
    logic [31:0] nw;
    idx = int'(a >> 2);
    off = int'(a & 32'd3);
    nb = 1 << sz;
    m_err = (sz == 2'b11) || ((a % nb) != 0) || (idx >= 64);
    m_rdata = 32'h0;
    m_merged = 32'h0;
    bs = A;
    if (m_err) begin
      rsp[A] = {1'b1, 32'h0};
      be = A;
    end else if (!w) begin
      v = 64'(ref_mem[idx]) >> (8 * off);
      msk = (64'd1 << (8 * nb)) - 64'd1;
      v = v & msk;
      if (sg && nb < 4 && v[8*nb-1]) v = v | ~msk;
      m_rdata = v[31:0];
      mr_a[A] = 32'(idx);
      rsp[A+1] = {1'b0, m_rdata};
      be = A + 1;
      m_loads++;
    end else begin
      nw = ref_mem[idx];
      for (int b = 0; b < nb; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
      m_merged = nw;
      ref_mem[idx] = nw;
      if (nb == 4) begin
        mw_a[A] = 32'(idx);
        mw_d[A] = nw;
        rsp[A+1] = {1'b0, 32'h0};
        be = A + 1;
      end else begin
        mr_a[A] = 32'(idx);
        mw_a[A+1] = 32'(idx);
        mw_d[A+1] = nw;
        rsp[A+2] = {1'b0, 32'h0};
        be = A + 2;
      end
      m_stores++;
    end
  endtask

  task automatic present(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit ok);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = req_ready;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", t);
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    present(w, sz, sg, a, wd, ok);
    if (ok) begin
      model_req(cyc + 1, w, sz, sg, a, wd);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = $urandom;
      req_wdata = $urandom;
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic rst_mid_store(input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    logic [31:0] old;
    old = ref_mem[a[7:2]];
    present(1'b1, 2'b10, 1'b0, a, wd, ok);
    if (ok) begin
      bs = cyc + 1;
      be = cyc + 1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_loads = 0;
      m_stores = 0;
    end
    settle();
    chk("t5_mem_kept", mem[a[7:2]], old);
  endtask

  initial begin
    bit w;
    bit sg;
    int r;
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h8899_AABB;
    ref_mem[5] = 32'h8899_AABB;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", b32(req_ready), 32'd1);
    chk("rst_valid", b32(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", b32(resp_err), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_memread", b32(MemRead), 32'd0);
    chk("rst_memwrite", b32(MemWrite), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    issue(1'b0, 2'b00, 1'b1, 32'h15, 32'h0);
    chk("t1_model_rdata", m_rdata, 32'hFFFF_FFAA);
    settle();

    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1234);
    chk("t2_model_merged", m_merged, 32'h1234_AABB);
    settle();
    chk("t2_mem", mem[5], 32'h1234_AABB);

    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
    chk("t3_model_wdata", m_merged, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    chk("t3_model_rdata", m_rdata, 32'hDEAD_BEEF);
    settle();

    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    chk("t4_misalign", b32(m_err), 32'd1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("t4_size11", b32(m_err), 32'd1);
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    chk("t4_range", b32(m_err), 32'd1);
    settle();

    rst_mid_store(32'h20, 32'h1234_5678);

    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00C3);
    issue(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
    issue(1'b0, 2'b00, 1'b0, 32'h31, 32'h0);
    settle();
    chk("t6_model_loads", 32'(m_loads), 32'd3);
    chk("t6_model_stores", 32'(m_stores), 32'd2);
`ifdef MEM_ACCESS_CTRL_PERF_EN
    chk("t6_load_count", {16'h0, load_count}, 32'd3);
    chk("t6_store_count", {16'h0, store_count}, 32'd2);
`endif

    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      sg = 1'($urandom);
      r = int'($urandom % 8);
      sz = (r == 7) ? 2'b11 : 2'(r % 3);
      a = {22'h0, 8'($urandom_range(0, 69)), 2'($urandom)};
      if ($urandom % 20 == 0) a = $urandom;
      issue(w, sz, sg, a, $urandom);
      if ($urandom % 4 == 0) settle();
    end
    settle();

`ifdef MEM_ACCESS_CTRL_PERF_EN
    chk("final_load_count", {16'h0, load_count}, 32'(m_loads));
    chk("final_store_count", {16'h0, store_count}, 32'(m_stores));
`endif
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
